// File: rtl/fifo_read_stream_pkg.sv
// Shared types and sizing helpers for the fifo_read_stream drain engine.
package fifo_read_stream_pkg;
    localparam int STATS_W = 32;

    typedef logic [STATS_W-1:0] stats_cnt_t;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/sync_fifo_small.sv
// Single-clock circular buffer with push/pop and occupancy; DEPTH need not be a power of two.
module sync_fifo_small
    import fifo_read_stream_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int OCC_W = occ_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [BITS-1:0]  push_data,
    input  logic             pop,
    output logic [BITS-1:0]  pop_data,
    output logic [OCC_W-1:0] occ
);
    logic [BITS-1:0]  mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // A pop request against an empty buffer is ignored.
    assign do_pop   = pop && (occ != '0);
    assign pop_data = (occ != '0) ? mem[head] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else begin
            if (push) begin
                tail <= wrap_inc(tail);
            end
            if (do_pop) begin
                head <= wrap_inc(head);
            end
            case ({push, do_pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[tail] <= push_data;
        end
    end

    // The issuer's credit rule makes a push into a full buffer unreachable.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && (occ == OCC_W'(DEPTH))))
        else $error("sync_fifo_small: push while full");
endmodule

// File: rtl/fifo_read_stream.sv
// Read-domain drain engine: credit-limited pops from async_fifo into a local buffer, exposed as a stream.
// Optional accepted-word counter on m_count when FIFO_READ_STREAM_STATS_EN is defined.
module fifo_read_stream
    import fifo_read_stream_pkg::*;
#(
    parameter int BITS  = 32,
    parameter int DEPTH = 4
) (
    input  logic            read_clk,
    input  logic            read_rst_n,
    output logic            p_read_en,
    input  logic [BITS-1:0] p_read_data,
    input  logic            p_read_empty,
    output logic            m_valid,
    output logic [BITS-1:0] m_data,
    input  logic            m_ready
`ifdef FIFO_READ_STREAM_STATS_EN
    ,
    output stats_cnt_t      m_count
`endif
);
    localparam int OCC_W = occ_w(DEPTH);

    logic             inflight;
    logic [OCC_W-1:0] occ;
    logic [OCC_W:0]   used;
    logic             hs;

    // Buffered words plus the word already returning must leave room for one more.
    assign used      = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};
    assign p_read_en = read_rst_n && !p_read_empty && (used < (OCC_W+1)'(DEPTH));

    // Stream handshake: a word transfers on a rising edge where m_valid and m_ready are both 1;
    // m_valid/m_data depend only on registered occupancy and never on m_ready.
    assign m_valid = (occ != '0);
    assign hs      = m_valid && m_ready;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= p_read_en;
        end
    end

    sync_fifo_small #(
        .BITS  (BITS),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk       (read_clk),
        .rst_n     (read_rst_n),
        .push      (inflight),
        .push_data (p_read_data),
        .pop       (hs),
        .pop_data  (m_data),
        .occ       (occ)
    );

`ifdef FIFO_READ_STREAM_STATS_EN
    stats_cnt_t stat_cnt;

    always_ff @(posedge read_clk or negedge read_rst_n) begin
        if (!read_rst_n) begin
            stat_cnt <= '0;
        end else if (hs) begin
            stat_cnt <= stat_cnt + STATS_W'(1);
        end
    end

    assign m_count = stat_cnt;
`endif
endmodule

// File: tb/tb_fifo_read_stream.sv
// Bench for fifo_read_stream: a DEPTH=4 instance and a DEPTH=2 instance, each fed by a behavioural FIFO model.
module tb_fifo_read_stream;
    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [1:0]   rd_en;
    logic [1:0]   empty;
    logic [1:0]   m_valid;
    logic [1:0]   m_ready;
    logic [W-1:0] rd_data [2];
    logic [W-1:0] m_data  [2];
`ifdef FIFO_READ_STREAM_STATS_EN
    logic [31:0]  m_count [2];
`endif

    fifo_read_stream #(.BITS(W), .DEPTH(4)) dut (
        .read_clk     (clk),
        .read_rst_n   (rst_n),
        .p_read_en    (rd_en[0]),
        .p_read_data  (rd_data[0]),
        .p_read_empty (empty[0]),
        .m_valid      (m_valid[0]),
        .m_data       (m_data[0]),
        .m_ready      (m_ready[0])
`ifdef FIFO_READ_STREAM_STATS_EN
        , .m_count    (m_count[0])
`endif
    );

    fifo_read_stream #(.BITS(W), .DEPTH(2)) dut2 (
        .read_clk     (clk),
        .read_rst_n   (rst_n),
        .p_read_en    (rd_en[1]),
        .p_read_data  (rd_data[1]),
        .p_read_empty (empty[1]),
        .m_valid      (m_valid[1]),
        .m_data       (m_data[1]),
        .m_ready      (m_ready[1])
`ifdef FIFO_READ_STREAM_STATS_EN
        , .m_count    (m_count[1])
`endif
    );

    typedef struct {
        logic         push_v;
        logic [W-1:0] word;
        logic         ready;
        logic         exp_en;
        logic         exp_valid;
        logic [W-1:0] exp_data;
    } vec_t;

    vec_t         vecs [18];
    logic [W-1:0] src_q [2][$];
    logic [W-1:0] exp_q [2][$];
    logic         pop_now [2];
    int           tests;
    int           fails;
    int           cyc;
    int           hs_cnt [2];
    int           first_hs [2];
    int           last_hs [2];
    int           max_out;

    function automatic vec_t mk(input logic pv, input logic [W-1:0] w, input logic rdy,
                                input logic en, input logic vld, input logic [W-1:0] d);
        vec_t v;
        v.push_v = pv; v.word = w; v.ready = rdy;
        v.exp_en = en; v.exp_valid = vld; v.exp_data = d;
        return v;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [W-1:0] w);
        src_q[k].push_back(w);
        exp_q[k].push_back(w);
    endtask

    // Rising edge: model the FIFO read port (pop sampled at the edge, data valid next cycle).
    task automatic advance();
        @(posedge clk);
        for (int k = 0; k < 2; k++) pop_now[k] = rd_en[k] && !empty[k];
        cyc++;
        #1;
        for (int k = 0; k < 2; k++) rd_data[k] = pop_now[k] ? src_q[k].pop_front() : 32'hDEAD_BEEF;
    endtask

    // Falling edge: refresh empty flags from earlier in the cycle, then score handshakes.
    task automatic settle();
        int outstanding;
        for (int k = 0; k < 2; k++) empty[k] = (src_q[k].size() == 0);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (m_valid[k] && m_ready[k]) begin
                if (exp_q[k].size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_extra%0d: got %h expected no word", k, m_data[k]);
                end else begin
                    check($sformatf("sb_order%0d", k), m_data[k], exp_q[k].pop_front());
                end
                hs_cnt[k]++;
                if (hs_cnt[k] == 1) first_hs[k] = cyc;
                last_hs[k] = cyc;
            end
        end
        outstanding = int'(dut2.u_buf.occ) + int'(dut2.inflight);
        if (outstanding > max_out) max_out = outstanding;
    endtask

    task automatic cycle();
        advance();
        settle();
    endtask

    task automatic check_idle(input string name);
        check({name, "_en"},    32'(rd_en[0]),   32'd0);
        check({name, "_valid"}, 32'(m_valid[0]), 32'd0);
        check({name, "_data"},  m_data[0],       32'd0);
    endtask

    initial begin
        vecs[0]  = mk(0, 32'h0,         0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 32'hA5A5_0001, 0, 1, 0, 32'h0);
        vecs[2]  = mk(0, 32'h0,         0, 0, 0, 32'h0);
        vecs[3]  = mk(0, 32'h0,         0, 0, 1, 32'hA5A5_0001);
        vecs[4]  = mk(0, 32'h0,         1, 0, 1, 32'hA5A5_0001);
        vecs[5]  = mk(0, 32'h0,         1, 0, 0, 32'h0);
        vecs[6]  = mk(1, 32'h11,        0, 1, 0, 32'h0);
        vecs[7]  = mk(1, 32'h22,        0, 1, 0, 32'h0);
        vecs[8]  = mk(1, 32'h33,        0, 1, 1, 32'h11);
        vecs[9]  = mk(1, 32'h44,        0, 1, 1, 32'h11);
        vecs[10] = mk(1, 32'h55,        0, 0, 1, 32'h11);
        vecs[11] = mk(0, 32'h0,         0, 0, 1, 32'h11);
        vecs[12] = mk(0, 32'h0,         1, 0, 1, 32'h11);
        vecs[13] = mk(0, 32'h0,         1, 1, 1, 32'h22);
        vecs[14] = mk(0, 32'h0,         1, 0, 1, 32'h33);
        vecs[15] = mk(0, 32'h0,         1, 0, 1, 32'h44);
        vecs[16] = mk(0, 32'h0,         1, 0, 1, 32'h55);
        vecs[17] = mk(0, 32'h0,         1, 0, 0, 32'h0);

        tests = 0; fails = 0; cyc = 0; max_out = 0;
        hs_cnt = '{0, 0}; first_hs = '{0, 0}; last_hs = '{0, 0};
        rst_n = 1'b0; empty = 2'b11; m_ready = 2'b00;
        rd_data[0] = 32'hDEAD_BEEF; rd_data[1] = 32'hDEAD_BEEF;

        // Reset state
        settle();
        check_idle("reset");
        check("reset_en2", 32'(rd_en[1]), 32'd0);
        cycle();
        advance();
        rst_n = 1'b1;
        settle();

        // Table: first-word latency, ready-without-valid, credit stall at DEPTH, drain
        for (int i = 0; i < 18; i++) begin
            advance();
            if (vecs[i].push_v) push(0, vecs[i].word);
            m_ready[0] = vecs[i].ready;
            settle();
            check($sformatf("vec%0d_en", i),    32'(rd_en[0]),   32'(vecs[i].exp_en));
            check($sformatf("vec%0d_valid", i), 32'(m_valid[0]), 32'(vecs[i].exp_valid));
            check($sformatf("vec%0d_data", i),  m_data[0],       vecs[i].exp_data);
        end

        // Backpressure: 10 queued words, buffer saturates at 4, then drains gap-free
        advance();
        m_ready[0] = 1'b0;
        for (int i = 0; i < 10; i++) push(0, 32'($urandom_range(0, 32'h7FFF_FFFF)));
        settle();
        repeat (12) cycle();
        check("bp_occ", 32'(dut.u_buf.occ), 32'd4);
        check("bp_en",  32'(rd_en[0]),      32'd0);
        cycle();
        check("bp_en_hold", 32'(rd_en[0]), 32'd0);
        hs_cnt[0] = 0;
        advance();
        m_ready[0] = 1'b1;
        settle();
        repeat (9) cycle();
        check("bp_count", 32'(hs_cnt[0]),               32'd10);
        check("bp_span",  32'(last_hs[0] - first_hs[0]), 32'd9);
        cycle();
        check("bp_drained", 32'(m_valid[0]), 32'd0);

        // Streaming 0..99 with the source never empty
        hs_cnt[0] = 0;
        advance();
        for (int i = 0; i < 100; i++) push(0, 32'(i));
        settle();
        for (int t = 0; t < 200 && hs_cnt[0] < 100; t++) cycle();
        check("stream_count", 32'(hs_cnt[0]),               32'd100);
        check("stream_span",  32'(last_hs[0] - first_hs[0]), 32'd99);
        check("stream_left",  32'(exp_q[0].size()),         32'd0);

        // DEPTH=2 credit bound under continuous traffic
        hs_cnt[1] = 0;
        max_out = 0;
        advance();
        m_ready[1] = 1'b1;
        for (int i = 0; i < 20; i++) push(1, 32'hB000_0000 + 32'(i));
        settle();
        for (int t = 0; t < 100 && hs_cnt[1] < 20; t++) cycle();
        check("d2_count", 32'(hs_cnt[1]), 32'd20);
        check("d2_max_outstanding", 32'(max_out), 32'd2);

        // Reset mid-stream with 3 words buffered
        advance();
        m_ready[0] = 1'b0;
        for (int i = 0; i < 3; i++) push(0, 32'hC000_0000 + 32'(i));
        settle();
        repeat (5) cycle();
        check("rst_pre_occ", 32'(dut.u_buf.occ), 32'd3);
        advance();
        rst_n = 1'b0;
        src_q[0].push_back(32'hC0FF_EE00);
        settle();
        check_idle("rst_now");
        repeat (2) begin
            cycle();
            check_idle("rst_hold");
        end
        advance();
        src_q[0].delete();
        exp_q[0].delete();
        rst_n = 1'b1;
        settle();
        check_idle("rst_rel");
        cycle();
        check_idle("rst_rel2");
        advance();
        push(0, 32'hA5A5_0002);
        m_ready[0] = 1'b1;
        settle();
        check("post_rst_en", 32'(rd_en[0]), 32'd1);
        cycle();
        check("post_rst_valid_n1", 32'(m_valid[0]), 32'd0);
        cycle();
        check("post_rst_valid_n2", 32'(m_valid[0]), 32'd1);
        check("post_rst_data",     m_data[0],        32'hA5A5_0002);
        cycle();

`ifdef FIFO_READ_STREAM_STATS_EN
        // Counter wrap: preload near the top, then three handshakes
        advance();
        m_ready[0] = 1'b0;
        settle();
        force dut.stat_cnt = 32'hFFFF_FFFE;
        cycle();
        release dut.stat_cnt;
        check("stats_preload", m_count[0], 32'hFFFF_FFFE);
        advance();
        m_ready[0] = 1'b1;
        for (int i = 0; i < 3; i++) push(0, 32'hD000_0000 + 32'(i));
        settle();
        repeat (8) cycle();
        check("stats_wrap", m_count[0], 32'd1);
`endif

        check("final_q0", 32'(exp_q[0].size()), 32'd0);
        check("final_q1", 32'(exp_q[1].size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
